// File: rtl/ym2149_frame_seq_pkg.sv
// rtl/ym2149_frame_seq_pkg.sv - shared types and constants for the YM2149 frame sequencer
// Contents: seq_state_e (FSM states), seq_cmd_t (queued command), WB_SEL_BYTE0,
//           wait_frames() helper mapping a wait marker's data byte to a frame count.
package ym2149_frame_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_REQ   = 3'd2,
      ST_ACK   = 3'd3,
      ST_WAIT  = 3'd4
   } seq_state_e;

   // is_wait stands in for the "wait" field; wait is a reserved word.
   typedef struct packed {
      logic       is_wait;
      logic [7:0] adr;
      logic [7:0] dat;
   } seq_cmd_t;

   localparam logic [3:0] WB_SEL_BYTE0 = 4'b0001;

   // A zero-frame wait still waits one frame so a marker is never a no-op.
   function automatic logic [7:0] wait_frames(input logic [7:0] n);
      return (n == 8'd0) ? 8'd1 : n;
   endfunction

endpackage

// File: rtl/ym2149_seq_fifo.sv
// rtl/ym2149_seq_fifo.sv - synchronous command FIFO with level output and flush
// Ports: clk, rst (sync, active-high), flush (clears contents, blocks push/pop),
//        push/wr_data, pop/rd_data (head, valid when !empty), full, empty, level.
module ym2149_seq_fifo
   import ym2149_frame_seq_pkg::*;
#(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  seq_cmd_t      wr_data,
   input  logic          pop,
   output seq_cmd_t      rd_data,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   seq_cmd_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full    = (level_q == DEPTH_L);
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      // A flush cycle discards any push and pop presented with it.
      do_push  = push && !full && !flush;
      do_pop   = pop && !empty && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      level_d = level_q + LW'(1);
         else if (!do_push && do_pop) level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/ym2149_frame_sequencer.sv
// rtl/ym2149_frame_sequencer.sv - frame-paced YM2149 register-write sequencer (Wishbone master)
// Ports: clk, rst (sync, active-high), enable, flush;
//        cmd_valid/cmd_ready/cmd_wait/cmd_adr/cmd_dat command push interface;
//        wbm_* pipelined Wishbone master (single writes);
//        fifo_level, busy, bus_err (sticky), frame_tick, refill_irq.
// Optional: define YM2149_FRAME_SEQ_REFILL_IRQ_EN to enable the low-water refill_irq pulse.
module ym2149_frame_sequencer
   import ym2149_frame_seq_pkg::*;
#(
   parameter  int          CLK_HZ      = 50000000,
   parameter  int          FRAME_HZ    = 50,
   parameter  int          FIFO_DEPTH  = 64,
   parameter  logic [31:0] PSG_BASE    = 32'h10001000,
   parameter  int          ACK_TIMEOUT = 255,
   parameter  int          LOW_WATER   = 16,
   localparam int          LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             flush,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wait,
   input  logic [7:0]       cmd_adr,
   input  logic [7:0]       cmd_dat,
   output logic             wbm_cyc,
   output logic             wbm_stb,
   output logic             wbm_we,
   output logic [31:0]      wbm_adr,
   output logic [31:0]      wbm_dat_w,
   output logic [3:0]       wbm_sel,
   input  logic             wbm_stall,
   input  logic             wbm_ack,
   input  logic             wbm_err,
   output logic [LVL_W-1:0] fifo_level,
   output logic             busy,
   output logic             bus_err,
   output logic             frame_tick,
   output logic             refill_irq
);

   localparam logic [31:0] PERIOD_M1 = 32'(CLK_HZ / FRAME_HZ - 1);
   localparam int          TO_W      = $clog2(ACK_TIMEOUT + 1);
   // ACK is left after exactly ACK_TIMEOUT cycles without a response.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   // ---------------- command FIFO ----------------
   seq_cmd_t fifo_wdata, fifo_head;
   logic     fifo_pop, fifo_full, fifo_empty;

   assign fifo_wdata = '{is_wait: cmd_wait, adr: cmd_adr, dat: cmd_dat};
   assign cmd_ready  = !fifo_full;

   ym2149_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .push    (cmd_valid),
      .wr_data (fifo_wdata),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // ---------------- state ----------------
   logic [31:0]     frame_cnt_q, frame_cnt_d;
   logic            frame_tick_q, frame_tick_d;
   seq_state_e      state_q, state_d;
   seq_cmd_t        hold_q, hold_d;
   logic [7:0]      wait_cnt_q, wait_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            bus_err_q, bus_err_d;
   logic            cyc_q, cyc_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic [31:0]     adr_q, adr_d;
   logic [31:0]     dat_q, dat_d;
   logic [3:0]      sel_q, sel_d;
   logic            busy_q, busy_d;

   // Frame counter: frame_tick goes high in the cycle the count is 0 again.
   always_comb begin
      frame_cnt_d  = frame_cnt_q;
      frame_tick_d = 1'b0;
      if (enable) begin
         if (frame_cnt_q == PERIOD_M1) begin
            frame_cnt_d  = '0;
            frame_tick_d = 1'b1;
         end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      wait_cnt_d = wait_cnt_q;
      to_cnt_d   = to_cnt_q;
      bus_err_d  = bus_err_q;
      fifo_pop   = 1'b0;
      if (flush) bus_err_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (enable && !fifo_empty && !flush) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // A flush here (or in the IDLE cycle before) has removed the head.
            if (fifo_empty || flush) begin
               state_d = ST_IDLE;
            end else begin
               fifo_pop = 1'b1;
               hold_d   = fifo_head;
               if (fifo_head.is_wait) begin
                  wait_cnt_d = wait_frames(fifo_head.dat);
                  state_d    = ST_WAIT;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            to_cnt_d = '0;
            if (!wbm_stall) state_d = ST_ACK;
         end
         ST_ACK: begin
            // err wins over a simultaneous ack; a failed write is dropped.
            if (wbm_err) begin
               state_d   = ST_IDLE;
               bus_err_d = 1'b1;
            end else if (wbm_ack) begin
               state_d = ST_IDLE;
            end else if (to_cnt_q == TO_LAST) begin
               state_d   = ST_IDLE;
               bus_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_WAIT: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (frame_tick_q) begin
               if (wait_cnt_q <= 8'd1) state_d = ST_IDLE;
               else                    wait_cnt_d = wait_cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs are registered from the next state so they line up with it.
   always_comb begin
      cyc_d  = (state_d == ST_REQ) || (state_d == ST_ACK);
      stb_d  = (state_d == ST_REQ);
      we_d   = (state_d == ST_REQ);
      sel_d  = cyc_d ? WB_SEL_BYTE0 : 4'b0000;
      adr_d  = cyc_d ? (PSG_BASE + {22'b0, hold_d.adr, 2'b00}) : 32'h0;
      dat_d  = cyc_d ? {24'b0, hold_d.dat} : 32'h0;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q  <= '0;
         frame_tick_q <= 1'b0;
         state_q      <= ST_IDLE;
         hold_q       <= '0;
         wait_cnt_q   <= '0;
         to_cnt_q     <= '0;
         bus_err_q    <= 1'b0;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         frame_cnt_q  <= frame_cnt_d;
         frame_tick_q <= frame_tick_d;
         state_q      <= state_d;
         hold_q       <= hold_d;
         wait_cnt_q   <= wait_cnt_d;
         to_cnt_q     <= to_cnt_d;
         bus_err_q    <= bus_err_d;
         cyc_q        <= cyc_d;
         stb_q        <= stb_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         busy_q       <= busy_d;
      end
   end

   assign wbm_cyc    = cyc_q;
   assign wbm_stb    = stb_q;
   assign wbm_we     = we_q;
   assign wbm_adr    = adr_q;
   assign wbm_dat_w  = dat_q;
   assign wbm_sel    = sel_q;
   assign busy       = busy_q;
   assign bus_err    = bus_err_q;
   assign frame_tick = frame_tick_q;

`ifdef YM2149_FRAME_SEQ_REFILL_IRQ_EN
   logic refill_irq_q, refill_irq_d;

   // Registered alongside frame_tick so both pulse in the same cycle.
   always_comb begin
      refill_irq_d = frame_tick_d && enable && (32'(fifo_level) < 32'(LOW_WATER));
   end

   always_ff @(posedge clk) begin
      if (rst) refill_irq_q <= 1'b0;
      else     refill_irq_q <= refill_irq_d;
   end

   assign refill_irq = refill_irq_q;
`else
   assign refill_irq = 1'b0;
`endif

endmodule

// File: tb/tb_ym2149_frame_sequencer.sv
// tb/tb_ym2149_frame_sequencer.sv - self-checking bench for ym2149_frame_sequencer
module tb_ym2149_frame_sequencer;

   localparam int PERIOD = 100;

`ifdef YM2149_FRAME_SEQ_REFILL_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wait = 1'b0;
   logic [7:0]  cmd_adr = '0;
   logic [7:0]  cmd_dat = '0;
   logic        wbm_cyc, wbm_stb, wbm_we;
   logic [31:0] wbm_adr, wbm_dat_w;
   logic [3:0]  wbm_sel;
   logic        wbm_stall = 1'b0;
   logic        wbm_ack = 1'b0;
   logic        wbm_err = 1'b0;
   logic [6:0]  fifo_level;
   logic        busy, bus_err, frame_tick, refill_irq;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] exp_q[$];
   int   stall_left = 0, stall_seen = 0, adr_changes = 0, accepted = 0;
   bit   no_ack = 0, err_mode = 0, ack_next = 0, err_next = 0;
   logic [31:0] stall_adr = '0;

   ym2149_frame_sequencer #(
      .CLK_HZ(1000), .FRAME_HZ(10), .FIFO_DEPTH(64), .PSG_BASE(32'h10001000),
      .ACK_TIMEOUT(10), .LOW_WATER(16)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wait(cmd_wait),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
      .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we), .wbm_adr(wbm_adr),
      .wbm_dat_w(wbm_dat_w), .wbm_sel(wbm_sel), .wbm_stall(wbm_stall),
      .wbm_ack(wbm_ack), .wbm_err(wbm_err), .fifo_level(fifo_level), .busy(busy),
      .bus_err(bus_err), .frame_tick(frame_tick), .refill_irq(refill_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   // Wishbone slave: optional stall, ack (or ack+err) one cycle after acceptance;
   // accepted writes are popped from the scoreboard and compared.
   always @(negedge clk) begin
      logic [15:0] e;
      logic [31:0] ea;
      wbm_ack  = ack_next;
      wbm_err  = err_next;
      ack_next = 0;
      err_next = 0;
      wbm_stall = 1'b0;
      if (!rst && wbm_cyc && wbm_stb) begin
         if (stall_left > 0) begin
            if (stall_seen == 0) stall_adr = wbm_adr;
            else if (wbm_adr !== stall_adr) adr_changes++;
            wbm_stall = 1'b1;
            stall_left--;
            stall_seen++;
         end else begin
            accepted++;
            if (err_mode) begin
               ack_next = 1;
               err_next = 1;
            end else if (!no_ack) begin
               ack_next = 1;
            end
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL wb_unexpected_write adr=%h dat=%h", wbm_adr, wbm_dat_w);
            end else begin
               e  = exp_q.pop_front();
               ea = 32'h10001000 + {22'b0, e[15:8], 2'b00};
               if (wbm_adr !== ea || wbm_dat_w !== {24'b0, e[7:0]} || wbm_sel !== 4'b0001 || wbm_we !== 1'b1)
                  begin
                     miscompares++;
                     $display("FAIL wb_write got adr=%h dat=%h sel=%b we=%b want adr=%h dat=%h sel=0001 we=1",
                              wbm_adr, wbm_dat_w, wbm_sel, wbm_we, ea, {24'b0, e[7:0]});
                  end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1; enable = 0; flush = 0; cmd_valid = 0; cmd_wait = 0; cmd_adr = 0; cmd_dat = 0;
      stall_left = 0; stall_seen = 0; adr_changes = 0; accepted = 0;
      no_ack = 0; err_mode = 0; ack_next = 0; err_next = 0;
      exp_q.delete();
      repeat (3) step();
      rst = 0;
   endtask

   task automatic push_cmd(input logic w, input logic [7:0] a, input logic [7:0] d, input bit exec);
      if (exec && !w) exp_q.push_back({a, d});
      cmd_valid = 1; cmd_wait = w; cmd_adr = a; cmd_dat = d;
      step();
      cmd_valid = 0; cmd_wait = 0;
   endtask

   task automatic pulse_flush();
      flush = 1;
      step();
      flush = 0;
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 0;
      for (int i = 0; i < max; i++) begin
         step();
         if (!busy && fifo_level == 0 && exp_q.size() == 0 && !wbm_cyc) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] got;
      rst = 1;
      step();
      got = {cmd_ready, wbm_cyc, wbm_stb, wbm_we, busy, bus_err, frame_tick, refill_irq, fifo_level, 1'b0};
      vectors++;
      if (got !== 16'b1000_0000_0000_0000) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 1000000000000000", got);
      end
      vectors++;
      if ({wbm_adr, wbm_dat_w, wbm_sel} !== 68'h0) begin
         miscompares++;
         $display("FAIL reset_bus got adr=%h dat=%h sel=%b want zeros", wbm_adr, wbm_dat_w, wbm_sel);
      end
      do_reset();
   endtask

   task automatic test_two_writes();
      bit ok;
      do_reset();
      push_cmd(0, 8'd7, 8'h38, 1);
      push_cmd(0, 8'd8, 8'h0F, 1);
      enable = 1;
      wait_idle(20, ok);
      vectors++;
      if (!ok || accepted != 2) begin
         miscompares++;
         $display("FAIL two_writes idle=%0d accepted=%0d want idle=1 accepted=2", ok, accepted);
      end
      vectors++;
      if (bus_err !== 1'b0) begin
         miscompares++;
         $display("FAIL two_writes_bus_err got %b want 0", bus_err);
      end
   endtask

   task automatic test_frame_tick();
      int n;
      do_reset();
      enable = 1;
      n = 0;
      for (int i = 1; i <= 300; i++) begin step(); if (frame_tick) begin n = i; break; end end
      vectors++;
      if (n != PERIOD) begin
         miscompares++;
         $display("FAIL first_tick got %0d cycles want %0d", n, PERIOD);
      end
      step();
      vectors++;
      if (frame_tick !== 1'b0) begin
         miscompares++;
         $display("FAIL tick_width got %b want 0", frame_tick);
      end
      n = 0;
      for (int i = 2; i <= 300; i++) begin step(); if (frame_tick) begin n = i; break; end end
      vectors++;
      if (n != PERIOD) begin
         miscompares++;
         $display("FAIL tick_period got %0d want %0d", n, PERIOD);
      end
      repeat (30) step();
      enable = 0;
      n = 0;
      for (int i = 0; i < 200; i++) begin step(); if (frame_tick) n++; end
      vectors++;
      if (n != 0) begin
         miscompares++;
         $display("FAIL tick_hold got %0d ticks want 0", n);
      end
      enable = 1;
      n = 0;
      for (int i = 1; i <= 300; i++) begin step(); if (frame_tick) begin n = i; break; end end
      vectors++;
      if (n != 70) begin
         miscompares++;
         $display("FAIL tick_resume got %0d want 70", n);
      end
   endtask

   task automatic test_wait(input logic [7:0] frames, input int want_ticks);
      int ticks, last_tick, at;
      bit ok;
      do_reset();
      push_cmd(1, 8'd0, frames, 1);
      push_cmd(0, 8'd0, 8'h55, 1);
      enable = 1;
      ticks = 0; last_tick = 0; at = -1;
      for (int i = 1; i <= 500; i++) begin
         step();
         if (frame_tick) begin ticks++; last_tick = i; end
         if (wbm_stb) begin at = i; break; end
      end
      vectors++;
      if (at < 0 || ticks != want_ticks || (at - last_tick) < 1 || (at - last_tick) > 4) begin
         miscompares++;
         $display("FAIL wait_%0d stb_at=%0d ticks=%0d delay=%0d want ticks=%0d delay 1..4",
                  frames, at, ticks, at - last_tick, want_ticks);
      end
      wait_idle(20, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL wait_%0d_drain got busy=%b want 0", frames, busy);
      end
   endtask

   task automatic test_stall();
      bit ok;
      do_reset();
      stall_left = 5;
      push_cmd(0, 8'd2, 8'hAA, 1);
      enable = 1;
      wait_idle(40, ok);
      vectors++;
      if (!ok || stall_seen != 5 || adr_changes != 0 || accepted != 1) begin
         miscompares++;
         $display("FAIL stall idle=%0d stalled=%0d adr_changes=%0d accepted=%0d want 1/5/0/1",
                  ok, stall_seen, adr_changes, accepted);
      end
   endtask

   task automatic test_timeout();
      int ack_cycles;
      bit ok;
      do_reset();
      no_ack = 1;
      push_cmd(0, 8'd1, 8'h11, 1);
      push_cmd(0, 8'd3, 8'h33, 1);
      enable = 1;
      ack_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (wbm_cyc && !wbm_stb) ack_cycles++;
         if (bus_err) break;
      end
      no_ack = 0;
      vectors++;
      if (bus_err !== 1'b1 || ack_cycles != 10 || wbm_cyc !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout bus_err=%b ack_cycles=%0d cyc=%b want 1/10/0", bus_err, ack_cycles, wbm_cyc);
      end
      wait_idle(30, ok);
      vectors++;
      if (!ok || accepted != 2 || bus_err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_next idle=%0d accepted=%0d bus_err=%b want 1/2/1", ok, accepted, bus_err);
      end
      pulse_flush();
      vectors++;
      if (bus_err !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_clears_err got %b want 0", bus_err);
      end
   endtask

   task automatic test_err();
      bit ok;
      do_reset();
      err_mode = 1;
      push_cmd(0, 8'd4, 8'h44, 1);
      enable = 1;
      wait_idle(30, ok);
      err_mode = 0;
      vectors++;
      if (!ok || bus_err !== 1'b1) begin
         miscompares++;
         $display("FAIL ack_with_err idle=%0d bus_err=%b want 1/1", ok, bus_err);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 64; i++) push_cmd(0, 8'($urandom_range(0, 15)), 8'($urandom), 0);
      vectors++;
      if (fifo_level !== 7'd64 || cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full level=%0d ready=%b want 64/0", fifo_level, cmd_ready);
      end
      push_cmd(0, 8'd9, 8'h99, 0);
      vectors++;
      if (fifo_level !== 7'd64 || wbm_cyc !== 1'b0) begin
         miscompares++;
         $display("FAIL push_when_full level=%0d cyc=%b want 64/0", fifo_level, wbm_cyc);
      end
      pulse_flush();
      vectors++;
      if (fifo_level !== 7'd0 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_level level=%0d ready=%b want 0/1", fifo_level, cmd_ready);
      end
   endtask

   task automatic test_flush_wait();
      do_reset();
      push_cmd(1, 8'd0, 8'd5, 0);
      enable = 1;
      repeat (10) step();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_wait_busy got %b want 1", busy);
      end
      pulse_flush();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_wait_abort got busy=%b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      enable = 1;
      for (int i = 0; i < 8; i++) push_cmd(0, 8'($urandom_range(0, 15)), 8'($urandom), 1);
      wait_idle(100, ok);
      vectors++;
      if (!ok || accepted != 8) begin
         miscompares++;
         $display("FAIL back_to_back idle=%0d accepted=%0d want 1/8", ok, accepted);
      end
   endtask

   task automatic test_refill_irq(input int n_writes);
      logic want_tick, want_irq;
      do_reset();
      push_cmd(1, 8'd0, 8'd20, 0);
      for (int i = 0; i < n_writes; i++) push_cmd(0, 8'(i), 8'(i), 0);
      enable = 1;
      for (int i = 1; i <= 250; i++) begin
         step();
         want_tick = (i % PERIOD == 0);
         want_irq  = IRQ_EN && want_tick && (n_writes < 16);
         vectors++;
         if (frame_tick !== want_tick || refill_irq !== want_irq) begin
            miscompares++;
            $display("FAIL refill_irq_lvl%0d cycle %0d tick=%b irq=%b want %b/%b",
                     n_writes, i, frame_tick, refill_irq, want_tick, want_irq);
         end
         if (i > 3) begin
            vectors++;
            if (fifo_level !== 7'(n_writes)) begin
               miscompares++;
               $display("FAIL refill_level cycle %0d got %0d want %0d", i, fifo_level, n_writes);
            end
         end
      end
      pulse_flush();
   endtask

   initial begin
      test_reset();
      test_two_writes();
      test_frame_tick();
      test_wait(8'd3, 3);
      test_wait(8'd0, 1);
      test_stall();
      test_timeout();
      test_err();
      test_full();
      test_flush_wait();
      test_back_to_back();
      test_refill_irq(3);
      test_refill_irq(20);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
